multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Instruction-driven control unit of the multicycle ARM core. Consumes the latched
//  instruction field Instr[31:12] and ALU flags. Sequences FETCH..writeback with a Moore
//  main FSM and gates register, memory and PC writes by condition code.
//  Drives every datapath enable and mux select.
// PARAMETERS
//  FLAG_RST  4'b0000  reset value of flag register {N,Z,C,V}
// PORTS
//  clk         in   1   clock
//  reset       in   1   synchronous, active-high reset
//  Instr       in   20  Instr[31:12]: cond[31:28], op[27:26], I[25], cmd[24:21], S/L[20]
//  ALUFlags    in   4   {N,Z,C,V} from ALU, current cycle
//  PCWrite     out  1   PC load enable
//  MemWrite    out  1   data memory write enable
//  RegWrite    out  1   register file write enable
//  IRWrite     out  1   instruction register load enable
//  AdrSrc      out  1   0=PC, 1=ALUOut as memory address
//  RegSrc      out  2   [0]=(op==10), [1]=(op==01)
//  ALUSrcA     out  2   00=RD1, 01=PC, 10=ALUOut
//  ALUSrcB     out  2   00=RD2/shift, 01=ExtImm, 10=const 4
//  ResultSrc   out  2   00=ALUOut, 01=Data, 10=ALUResult
//  ImmSrc      out  2   = op
//  ALUControl  out  2   00=ADD, 01=SUB, 10=AND, 11=ORR
// BEHAVIOUR
//  - States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
//  - FETCH->DECODE always.
//  - DECODE, by op:
//    - op=00: EXECI if I, else EXECR.
//    - op=01: MEMADR.
//    - op=10: BRANCH.
//    - op=11: FETCH (NOP, no writes).
//  - MEMADR->MEMRD if L, else MEMWR. MEMRD->MEMWB.
//  - EXECR/EXECI->ALUWB.
//  - MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
//  - Latency: DP=4 cycles, LDR=5, STR=4, B=3. Every instruction starts in FETCH.
//  - Per-state outputs (unlisted = 0):
//    - FETCH:  IRWrite=1, NextPC=1, AdrSrc=0, SrcA=01, SrcB=10, Result=10, ADD.
//    - DECODE: SrcA=01, SrcB=10, Result=10.
//    - MEMADR: SrcA=00, SrcB=01, ADD.
//    - MEMRD:  AdrSrc=1.
//    - MEMWB:  Result=01, RegW=1.
//    - MEMWR:  AdrSrc=1, MemW=1.
//    - EXECR:  SrcB=00, ALU decode.
//    - EXECI:  SrcB=01, ALU decode.
//    - ALUWB:  Result=00, RegW=1.
//    - BRANCH: SrcA=10, SrcB=01, Result=10, ADD, Branch=1.
//  - ALU decode (EXEC states only, else ADD):
//    - cmd 0100->00, 0010->01, 1010(CMP)->01, 0000->10, 1100->11.
//    - Any other cmd->00.
//  - CondEx:
//    - Combinational from cond and flag register; result latched into cond_q at end of DECODE.
//    - Gating uses cond_q, so an instruction's own flag update cannot cancel its writeback.
//    - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
//    - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
//    - AL(1110)=1; 1111=0.
//  - Write gating:
//    - PCWrite = NextPC | (Branch & cond_q).
//    - RegWrite = RegW & cond_q & !NoWrite. NoWrite=1 for op=00 & cmd=1010 (CMP).
//    - MemWrite = MemW & cond_q.
//  - Flags update at end of EXECR/EXECI when cond_q & S (CMP always updates):
//    - NZ always updated.
//    - CV updated only for ADD/SUB/CMP.
//  - Reset (sync):
//    - state=FETCH, flags=FLAG_RST, cond_q=0.
//    - While reset is high, PCWrite/MemWrite/RegWrite/IRWrite are forced 0.
//    - Mux selects show FETCH values.
//    - First cycle after deassert is FETCH with IRWrite=1.
//  - Reset mid-instruction: next edge returns to FETCH; flags restore FLAG_RST;
//    no partial writeback occurs.
//  - Instr must be stable from DECODE until return to FETCH (IR holds it).
//  - ALUFlags is sampled only at EXEC edges.
// STRUCTURE
//  - Package arm_mc_pkg:
//    - state encoding localparams (4-bit).
//    - op codes (DP=00, MEM=01, BR=10).
//    - cmd codes (AND, SUB, ADD, CMP, ORR).
//    - cond codes (EQ..AL).
//    - select encodings for SrcA, SrcB, Result, ALUControl.
//  - Sub-module cond_check: combinational; inputs cond[3:0], flags[3:0]; output cond_ex.
//  - Top module holds the FSM, decode, flag register and cond_q.
// TESTING
//  1. ADD R1,R2,R3 AL (Instr=20'hE0821), flags 0:
//     - PCWrite=1 in FETCH only; ALUControl=00 in EXECR.
//     - RegWrite=1 only in cycle 4; back to FETCH in cycle 5.
//  2. SUBS, result zero: ALUFlags=4'b0100 in EXECR -> flag reg=0100.
//     Next BEQ (Instr[31:20]=12'h0A0):
//     - 3 cycles.
//     - PCWrite=1 in FETCH and in BRANCH; SrcA=10, SrcB=01 in BRANCH.
//  3. BNE with Z=1:
//     - BRANCH reached but PCWrite=0 in BRANCH.
//     - Next FETCH follows in cycle 4.
//  4. LDR (Instr[31:20]=12'hE59):
//     - MEMADR, MEMRD, MEMWB over 5 cycles; AdrSrc=1 in MEMRD.
//     - RegWrite=1, ResultSrc=01 in cycle 5.
//     STR (12'hE58):
//     - 4 cycles; MemWrite=1 in cycle 4; RegWrite never asserted.
//  5. CMP R1,#0 (12'hE35):
//     - ALUControl=01; flags captured.
//     - RegWrite=0 in ALUWB.
//     ADDEQS with Z=1 whose result clears Z:
//     - RegWrite still 1 in ALUWB (cond_q).
//  6. Assert reset during MEMRD:
//     - All write enables 0 while reset is high.
//     - After release: FETCH, IRWrite=1, flags=FLAG_RST.

Source files
------------

// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, instruction
// fields, condition codes and datapath select values.
package arm_mc_pkg;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXECR  = 4'd6;
  localparam logic [3:0] ST_EXECI  = 4'd7;
  localparam logic [3:0] ST_ALUWB  = 4'd8;
  localparam logic [3:0] ST_BRANCH = 4'd9;

  typedef enum logic [3:0] {
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_MEMADR = ST_MEMADR,
    S_MEMRD  = ST_MEMRD,
    S_MEMWB  = ST_MEMWB,
    S_MEMWR  = ST_MEMWR,
    S_EXECR  = ST_EXECR,
    S_EXECI  = ST_EXECI,
    S_ALUWB  = ST_ALUWB,
    S_BRANCH = ST_BRANCH
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] SRCA_RD1    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_EXT  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: alu_decode = ALU_ADD;
      CMD_SUB: alu_decode = ALU_SUB;
      CMD_CMP: alu_decode = ALU_SUB;
      CMD_AND: alu_decode = ALU_AND;
      CMD_ORR: alu_decode = ALU_ORR;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_cond_check.sv
// Condition-code evaluator: decides whether an instruction's cond field passes
// against the current {N,Z,C,V} flag register.
module cond_check
  import arm_mc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle ARM control unit: Moore main FSM, ALU decode, flag register and
// condition-gated write enables for PC, register file and data memory.
module multicycle_control_fsm
  import arm_mc_pkg::*;
#(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  logic [3:0] cond;
  logic [1:0] op;
  logic       i_bit;
  logic [3:0] cmd;
  logic       s_bit;
  logic       unused_instr_low;

  assign cond             = Instr[19:16];
  assign op               = Instr[15:14];
  assign i_bit            = Instr[13];
  assign cmd              = Instr[12:9];
  assign s_bit            = Instr[8];
  assign unused_instr_low = ^Instr[7:0];

  state_e     state_q, state_d;
  state_e     out_st;
  logic [3:0] flags_q;
  logic       cond_q;
  logic       cond_ex;

  logic       next_pc, branch, reg_w, mem_w, ir_w;
  logic       is_cmp, no_write, in_exec, flag_upd, arith_cmd;

  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_DP:   state_d = i_bit ? S_EXECI : S_EXECR;
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = s_bit ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Condition is frozen at DECODE so a flag update in EXEC cannot cancel its own writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      cond_q <= 1'b0;
    end else if (state_q == S_DECODE) begin
      cond_q <= cond_ex;
    end
  end

  assign is_cmp    = (op == OP_DP) && (cmd == CMD_CMP);
  assign no_write  = is_cmp;
  assign in_exec   = (state_q == S_EXECR) || (state_q == S_EXECI);
  assign flag_upd  = in_exec && cond_q && (s_bit || is_cmp);
  assign arith_cmd = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= FLAG_RST;
    end else if (flag_upd) begin
      flags_q[3:2] <= ALUFlags[3:2];
      if (arith_cmd) begin
        flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // During reset the selects decode as FETCH; write enables are masked below.
  always_comb begin
    out_st     = reset ? S_FETCH : state_q;
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    ir_w       = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_RD1;
    ALUSrcB    = SRCB_RD2;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    case (out_st)
      S_FETCH: begin
        ir_w      = 1'b1;
        next_pc   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_EXT;
      end
      S_MEMRD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcB    = SRCB_RD2;
        ALUControl = alu_decode(cmd);
      end
      S_EXECI: begin
        ALUSrcB    = SRCB_EXT;
        ALUControl = alu_decode(cmd);
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        reg_w     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_ALUOUT;
        ALUSrcB   = SRCB_EXT;
        ResultSrc = RES_ALURES;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite  = ~reset & (next_pc | (branch & cond_q));
  assign RegWrite = ~reset & reg_w & cond_q & ~no_write;
  assign MemWrite = ~reset & mem_w & cond_q;
  assign IRWrite  = ~reset & ir_w;

  assign RegSrc = {op == OP_MEM, op == OP_BR};
  assign ImmSrc = op;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed vector table, reset
// corner sequences and randomized instructions against an instruction-level model.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pcw;
    logic       memw;
    logic       regw;
    logic       irw;
    logic       adrsrc;
    logic [1:0] regsrc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic [1:0] imm;
    logic [1:0] aluc;
  } outs_t;

  typedef struct {
    logic [19:0] ins;
    logic [3:0]  af;
    int          len;
    logic [7:0]  pcm;
    logic [7:0]  regm;
    logic [7:0]  memm;
    logic [3:0]  flg;
    string       nm;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  outs_t       dut_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [3:0]  mflags;

  multicycle_control_fsm #(.FLAG_RST(4'b0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
  );

  always #5 clk = ~clk;

  assign dut_o = '{pcw: PCWrite, memw: MemWrite, regw: RegWrite, irw: IRWrite,
                   adrsrc: AdrSrc, regsrc: RegSrc, srca: ALUSrcA, srcb: ALUSrcB,
                   res: ResultSrc, imm: ImmSrc, aluc: ALUControl};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Conditions come in complementary pairs; the low cond bit inverts the base test.
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (c[0] == 1'b0);
    endcase
    return base ^ c[0];
  endfunction

  function automatic int mlen(input logic [19:0] ins);
    case (ins[15:14])
      2'b00:   return 4;
      2'b01:   return ins[8] ? 5 : 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    if (cmd == 4'b0010 || cmd == 4'b1010) return 2'b01;
    if (cmd == 4'b0000) return 2'b10;
    if (cmd == 4'b1100) return 2'b11;
    return 2'b00;
  endfunction

  // Expected outputs for cycle k (0 = FETCH) of an instruction issued with flags fl.
  function automatic outs_t mdl(input logic [19:0] ins, input logic [3:0] fl,
                                input int k, input bit rst);
    outs_t o;
    logic [1:0] op;
    bit take, is_dp, is_ld, is_st, is_b;
    o = '0;
    op = ins[15:14];
    o.regsrc = {op == 2'b01, op == 2'b10};
    o.imm = op;
    take  = cond_holds(ins[19:16], fl);
    is_dp = (op == 2'b00);
    is_ld = (op == 2'b01) && ins[8];
    is_st = (op == 2'b01) && !ins[8];
    is_b  = (op == 2'b10);
    if (rst || k == 0) begin
      o.srca = 2'b01; o.srcb = 2'b10; o.res = 2'b10;
      if (!rst) begin o.irw = 1'b1; o.pcw = 1'b1; end
    end else if (k == 1) begin
      o.srca = 2'b01; o.srcb = 2'b10; o.res = 2'b10;
    end else if (is_dp && k == 2) begin
      o.srcb = ins[13] ? 2'b01 : 2'b00;
      o.aluc = alu_of(ins[12:9]);
    end else if (is_dp && k == 3) begin
      o.regw = take && (ins[12:9] != 4'b1010);
    end else if ((is_ld || is_st) && k == 2) begin
      o.srcb = 2'b01;
    end else if ((is_ld || is_st) && k == 3) begin
      o.adrsrc = 1'b1;
      o.memw = is_st && take;
    end else if (is_ld && k == 4) begin
      o.res = 2'b01;
      o.regw = take;
    end else if (is_b && k == 2) begin
      o.srca = 2'b10; o.srcb = 2'b01; o.res = 2'b10;
      o.pcw = take;
    end
    return o;
  endfunction

  function automatic logic [3:0] new_flags(input logic [19:0] ins, input logic [3:0] fl,
                                           input logic [3:0] af);
    logic [3:0] r;
    bit cmp;
    r = fl;
    cmp = (ins[12:9] == 4'b1010);
    if (ins[15:14] == 2'b00 && cond_holds(ins[19:16], fl) && (ins[8] || cmp)) begin
      r[3:2] = af[3:2];
      if (ins[12:9] == 4'b0100 || ins[12:9] == 4'b0010 || cmp) r[1:0] = af[1:0];
    end
    return r;
  endfunction

  // Entered just after the edge that puts the DUT in FETCH; returns after the final edge.
  task automatic run_instr(input logic [19:0] ins, input logic [3:0] af, input int len,
                           input bit rnd, input string nm,
                           output logic [7:0] pcm, output logic [7:0] regm,
                           output logic [7:0] memm);
    logic [3:0] exec_af;
    pcm = '0; regm = '0; memm = '0;
    exec_af = af;
    Instr = ins;
    for (int k = 0; k < len; k++) begin
      ALUFlags = rnd ? 4'($urandom) : af;
      if (k == 2) exec_af = ALUFlags;
      @(negedge clk);
      check($sformatf("%s cyc%0d ins=%h", nm, k + 1, ins), 32'(dut_o),
            32'(mdl(ins, mflags, k, 1'b0)));
      pcm[k]  = PCWrite;
      regm[k] = RegWrite;
      memm[k] = MemWrite;
      @(posedge clk);
      #1;
    end
    mflags = new_flags(ins, mflags, exec_af);
  endtask

  vec_t tbl[11];

  initial begin
    logic [7:0] pcm, regm, memm;
    logic [19:0] ins;
    logic [3:0]  cmds[5];

    tbl[0]  = '{20'hE0821, 4'h0, 4, 8'h01, 8'h08, 8'h00, 4'h0, "ADD_AL"};
    tbl[1]  = '{20'hE0512, 4'h4, 4, 8'h01, 8'h08, 8'h00, 4'h4, "SUBS_zero"};
    tbl[2]  = '{20'h0A000, 4'h0, 3, 8'h05, 8'h00, 8'h00, 4'h4, "BEQ_taken"};
    tbl[3]  = '{20'h1A000, 4'h0, 3, 8'h01, 8'h00, 8'h00, 4'h4, "BNE_not_taken"};
    tbl[4]  = '{20'hE5912, 4'h0, 5, 8'h01, 8'h10, 8'h00, 4'h4, "LDR"};
    tbl[5]  = '{20'hE5812, 4'h0, 4, 8'h01, 8'h00, 8'h08, 4'h4, "STR"};
    tbl[6]  = '{20'hE3510, 4'h6, 4, 8'h01, 8'h00, 8'h00, 4'h6, "CMP_imm"};
    tbl[7]  = '{20'h02912, 4'h0, 4, 8'h01, 8'h08, 8'h00, 4'h0, "ADDEQS_clearsZ"};
    tbl[8]  = '{20'hE1912, 4'hB, 4, 8'h01, 8'h08, 8'h00, 4'h8, "ORRS_keepCV"};
    tbl[9]  = '{20'hEC000, 4'h0, 2, 8'h01, 8'h00, 8'h00, 4'h8, "NOP_op11"};
    tbl[10] = '{20'h05812, 4'h0, 4, 8'h01, 8'h00, 8'h00, 4'h8, "STREQ_skipped"};

    reset = 1'b1;
    Instr = 20'hE0821;
    ALUFlags = 4'h0;
    mflags = 4'h0;

    // Reset held: enables masked, selects at FETCH values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 32'(dut_o), 32'(mdl(Instr, mflags, 0, 1'b1)));
    check("reset flags", 32'(dut.flags_q), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_instr(tbl[i].ins, tbl[i].af, tbl[i].len, 1'b0, tbl[i].nm, pcm, regm, memm);
      check({tbl[i].nm, " PCWrite cycles"}, 32'(pcm), 32'(tbl[i].pcm));
      check({tbl[i].nm, " RegWrite cycles"}, 32'(regm), 32'(tbl[i].regm));
      check({tbl[i].nm, " MemWrite cycles"}, 32'(memm), 32'(tbl[i].memm));
      check({tbl[i].nm, " flags"}, 32'(dut.flags_q), 32'(tbl[i].flg));
    end

    // Reset asserted while an LDR sits in MEMRD: no writeback, flags restored.
    ins = 20'hE5912;
    Instr = ins;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("ldr_pre_reset cyc%0d", k + 1), 32'(dut_o), 32'(mdl(ins, mflags, k, 1'b0)));
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("mid_reset hold%0d", k), 32'(dut_o), 32'(mdl(ins, mflags, 0, 1'b1)));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    mflags = 4'h0;
    @(negedge clk);
    check("post_reset fetch", 32'(dut_o), 32'(mdl(ins, mflags, 0, 1'b0)));
    check("post_reset flags", 32'(dut.flags_q), 32'h0);
    @(posedge clk);
    #1;
    // Finish the re-fetched LDR from DECODE so the model stays aligned.
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("ldr_refetch cyc%0d", k + 1), 32'(dut_o), 32'(mdl(ins, mflags, k, 1'b0)));
      @(posedge clk);
      #1;
    end

    // Random instructions; ALUFlags changes every cycle but only EXEC edges matter.
    cmds[0] = 4'b0000; cmds[1] = 4'b0010; cmds[2] = 4'b0100;
    cmds[3] = 4'b1010; cmds[4] = 4'b1100;
    for (int i = 0; i < 300; i++) begin
      ins[19:16] = 4'($urandom);
      ins[15:14] = 2'($urandom);
      ins[13]    = 1'($urandom);
      ins[12:9]  = ($urandom_range(0, 7) < 5) ? cmds[$urandom_range(0, 4)] : 4'($urandom);
      ins[8]     = 1'($urandom);
      ins[7:0]   = 8'($urandom);
      run_instr(ins, 4'h0, mlen(ins), 1'b1, $sformatf("rand%0d", i), pcm, regm, memm);
      if (i % 10 == 9) check($sformatf("rand%0d flags", i), 32'(dut.flags_q), 32'(mflags));
    end
    @(negedge clk);
    check("final fetch IRWrite", 32'(IRWrite), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
